// File: rtl/mult_div_if.sv
// mult_div_if: operand, control and HI/LO result bundle of the multiply/divide unit
interface mult_div_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, rs_data, rt_data, hi_we, lo_we, wdata, input busy, done, hi, lo);
  modport slave (input start, op, rs_data, rt_data, hi_we, lo_we, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiplier / restoring divider with HI/LO registers
module mult_div_unit #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  mult_div_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, mul_next, div_next, prod_fix;
  logic [WIDTH-1:0] opnd, a_raw, hi_q, lo_q, a_in_mag, b_in_mag, quo_fix, rem_fix, hi_nx, lo_nx;
  logic [WIDTH:0] mul_sum, div_sh, div_diff;
  logic is_div, neg_q, neg_r, b_zero, done_q, sa, sb, accept, last, busy_c;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == S_IDLE) ? (bus.start ? S_CALC : S_IDLE) :
               (state == S_CALC) ? (last ? S_FINISH : S_CALC) : S_IDLE;
  end
  always_comb begin
    busy_c = state != S_IDLE;
    accept = (state == S_IDLE) && bus.start;
    last = cnt == CW'(WIDTH - 1);
  end
  // signed ops work on magnitudes; result signs are reapplied at FINISH
  assign sa = ~bus.op[0] & bus.rs_data[WIDTH-1];
  assign sb = ~bus.op[0] & bus.rt_data[WIDTH-1];
  assign a_in_mag = sa ? -bus.rs_data : bus.rs_data;
  assign b_in_mag = sb ? -bus.rt_data : bus.rt_data;
  // acc holds {hi_part, lo_part}: product accumulator or {remainder, quotient}
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? opnd : {WIDTH{1'b0}}};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign div_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd};
  assign div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign hi_nx = !is_div ? prod_fix[2*WIDTH-1:WIDTH] : b_zero ? a_raw : rem_fix;
  assign lo_nx = !is_div ? prod_fix[WIDTH-1:0] : b_zero ? {WIDTH{1'b1}} : quo_fix;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      opnd <= '0;
      a_raw <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      b_zero <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= state == S_FINISH;
      if (accept) begin
        cnt <= '0;
        acc <= {{WIDTH{1'b0}}, bus.op[1] ? a_in_mag : b_in_mag};
        opnd <= bus.op[1] ? b_in_mag : a_in_mag;
        a_raw <= bus.rs_data;
        is_div <= bus.op[1];
        neg_q <= sa ^ sb;
        neg_r <= sa;
        b_zero <= bus.rt_data == '0;
      end else if (state == S_CALC) begin
        cnt <= cnt + 1'b1;
        acc <= is_div ? div_next : mul_next;
      end
      if (state == S_FINISH) begin
        hi_q <= hi_nx;
        lo_q <= lo_nx;
      end
      if (!busy_c && bus.hi_we) hi_q <= bus.wdata;
      if (!busy_c && bus.lo_we) lo_q <= bus.wdata;
    end
  end
  assign bus.busy = busy_c;
  assign bus.done = done_q;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative HI/LO multiply/divide unit that consumes the two register-file read operands (rs on data1, rt on data2). It executes MULT, MULTU, DIV and DIVU over a fixed multi-cycle sequence and holds results in architectural HI/LO registers. MFHI/MFLO read HI/LO directly; MTHI/MTLO write them. The core stalls on busy.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request a new operation; sampled only in IDLE.
op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
rs_data  input  WIDTH  operand A (multiplicand or dividend), from register-file data1.
rt_data  input  WIDTH  operand B (multiplier or divisor), from register-file data2.
hi_we  input  1  MTHI write enable.
lo_we  input  1  MTLO write enable.
wdata  input  WIDTH  MTHI/MTLO write data.
busy  output  1  operation in progress; the core stalls on this signal.
done  output  1  one-cycle pulse; HI/LO hold the new result during this cycle.
hi  output  WIDTH  HI register (high product or remainder).
lo  output  WIDTH  LO register (low product or quotient).

Behaviour:
- Reset (asynchronous, active-high): state returns to IDLE; hi=0, lo=0, busy=0, done=0; iteration counter and working registers are cleared. Reset asserted mid-operation aborts the operation, and HI/LO read 0.
- States and transitions:
  - IDLE: leaves to CALC only on start.
  - CALC: runs WIDTH iterations, then moves to FINISH.
  - FINISH: moves to IDLE.
- Start accept (edge E0, state IDLE, start=1):
  - op and the operands are latched.
  - Signed ops (MULT, DIV) convert operands to magnitudes and record the result signs.
  - busy=1 from the cycle after E0.
- CALC, edges E1..EWIDTH, one iteration per edge:
  - Multiply: shift-add, producing a 2*WIDTH-bit unsigned product.
  - Divide: restoring shift-subtract, producing quotient and remainder.
- FINISH, edge E(WIDTH+1):
  - Sign correction is applied. Product sign = signA^signB. Quotient sign = signA^signB. Remainder sign = signA.
  - hi/lo are written.
  - done=1 for exactly one cycle, busy=0, state returns to IDLE.
  - Total: busy is high for WIDTH+1 cycles; the result is visible WIDTH+1 cycles after the accept edge.
- Result mapping:
  - Multiply: hi = product[2W-1:W], lo = product[W-1:0].
  - Divide: lo = quotient, hi = remainder.
- Divide by zero (rt_data=0): full latency still applies; lo=all ones, hi=rs_data as latched (signed or unsigned).
- Signed overflow case, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Magnitudes are handled as unsigned WIDTH-bit values, so no special case is needed.
- start while busy is ignored; it is neither queued nor restarted.
- start in the same cycle as done is accepted, because the state is IDLE during the done cycle.
- MTHI/MTLO:
  - Applied at the clock edge only when busy=0.
  - Ignored while busy.
  - If coincident with an accepted start, the write is applied and later overwritten at FINISH.
  - hi_we and lo_we together write both registers.
- op and operand inputs are don't-care when no start is accepted.
- No combinational path from the inputs to hi, lo, busy or done; all outputs are registered.

Test Plan:
1. Reset, then MULT 7*6. Required: lo=42, hi=0, done exactly 33 cycles after the accept edge; busy high for 33 cycles.
2. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT 0xFFFFFFFF*0xFFFFFFFF (-1*-1) -> hi=0, lo=1. MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU 123/0 -> lo=0xFFFFFFFF, hi=123 after full latency.
5. start pulsed again mid-operation with different operands -> the original result completes unchanged. MTLO 0x55 while busy -> ignored. MTHI 0xAA while idle -> hi=0xAA next cycle.
6. Assert reset at iteration 10 of a MULT -> busy=0, hi=lo=0 immediately. A new MULT 2*3 after release -> lo=6. start held high through done -> back-to-back accept with no idle gap.
